s4ga_cfg_streamer: RTL

S4GA_CFG_STREAMER -- requirements
Module: s4ga_cfg_streamer

---
 rtl/s4ga_cfg_streamer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/s4ga_cfg_streamer.sv
// Configuration streamer for an s4ga fabric: holds one frame of config segments and,
// after a fabric reset pulse, replays them continuously. Optional frame_cnt output: S4GA_CFG_FRAME_CNT_EN.
module s4ga_cfg_streamer #(
    parameter int N       = 71,
    parameter int SI_W    = 4,
    parameter int LL      = 18,
    parameter int RST_CYC = 72,
    localparam int DEPTH  = N * LL,
    localparam int A_W    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            wr_en,
    input  logic [A_W-1:0]  wr_addr,
    input  logic [SI_W-1:0] wr_data,
    output logic            s4_rst,
    output logic [SI_W-1:0] s4_si,
    output logic            frame_done,
    output logic            busy,
    output logic [1:0]      state_dbg
`ifdef S4GA_CFG_FRAME_CNT_EN
    ,
    output logic [15:0]     frame_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int RC_W = $clog2(RST_CYC + 1);
    localparam logic [A_W-1:0]  LAST    = A_W'(DEPTH - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    state_t          state;
    state_t          next_state;
    logic [A_W-1:0]  rd_addr;
    logic [RC_W-1:0] rst_cnt;
    logic            stop_lat;
    logic            s4_rst_d;
    logic [SI_W-1:0] s4_si_d;
    logic            frame_done_d;

    logic [SI_W-1:0] mem [DEPTH];

    // Segment memory is not reset; host writes land in any state.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr <= LAST)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stop in RUN only takes effect once the frame's final segment is on the output.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RESET;
            RESET: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (rst_cnt == RC_LAST) begin
                    next_state = RUN;
                end
            end
            RUN:     if (frame_done && (stop_lat || stop)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered pins line up with state.
    always_comb begin
        s4_rst_d     = (next_state == RESET);
        s4_si_d      = '0;
        frame_done_d = 1'b0;
        if (next_state == RUN) begin
            s4_si_d      = mem[rd_addr];
            frame_done_d = (rd_addr == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s4_rst     <= 1'b0;
            s4_si      <= '0;
            frame_done <= 1'b0;
            rd_addr    <= '0;
            rst_cnt    <= '0;
            stop_lat   <= 1'b0;
        end else begin
            s4_rst     <= s4_rst_d;
            s4_si      <= s4_si_d;
            frame_done <= frame_done_d;
            rst_cnt    <= (state == RESET) ? rst_cnt + 1'b1 : '0;
            if (next_state == RUN) begin
                rd_addr <= (rd_addr == LAST) ? '0 : rd_addr + 1'b1;
            end else begin
                rd_addr <= '0;
            end
            if ((state == RUN) && (next_state == RUN)) begin
                stop_lat <= stop_lat | stop;
            end else begin
                stop_lat <= 1'b0;
            end
        end
    end

`ifdef S4GA_CFG_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if ((state != RESET) && (next_state == RESET)) begin
            frame_cnt <= '0;
        end else if (frame_done_d) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule
